// File: rtl/output_row_writer.sv
// Packs convolution result pixels into 16-bit words and writes them to the output SRAM.
// Partial words are flushed at row ends, and a terminator word follows the last row.
module output_row_writer #(
  parameter int          PIX_W        = 8,
  parameter int          PIX_PER_WORD = 2,
  parameter logic [11:0] BASE_ADDR    = 12'h000,
  parameter logic [15:0] TERM_WORD    = 16'h00FF
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             row_end,
  input  logic             frame_end,
  output logic [11:0]      dut_sram_write_address,
  output logic [15:0]      dut_sram_write_data,
  output logic             dut_sram_write_enable,
  output logic             busy,
  output logic             done,
  output logic             addr_wrap_err,
  output logic [2:0]       state_dbg
);

  // Handshake: there is no backpressure. A pixel is accepted in any ACTIVE cycle with
  // pix_valid=1, and each cycle with dut_sram_write_enable=1 carries exactly one word.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACTIVE = 3'd1,
    S_FLUSH  = 3'd2,
    S_TERM   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int            LW    = $clog2(PIX_PER_WORD) + 1;
  localparam logic [LW-1:0] LANES = LW'(PIX_PER_WORD);

  state_t        state_q, state_n;
  logic [LW-1:0] lane_cnt, lane_n, lane_sum;
  logic [15:0]   pack_reg, pack_n, pack_in;
  logic [11:0]   addr_ptr, ptr_n;
  logic [11:0]   wr_addr_n;
  logic [15:0]   wr_data_n;
  logic          wr_n, err_n, done_n;
  logic          take_pix, word_full, flush_req;

  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) state_q <= S_IDLE;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:   if (start) state_n = S_ACTIVE;
      S_ACTIVE: if (frame_end) state_n = S_FLUSH;
      S_FLUSH:  state_n = S_TERM;
      S_TERM:   state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // The pixel arriving with row_end/frame_end is merged before the flush decision.
  always_comb begin
    take_pix = (state_q == S_ACTIVE) && pix_valid;
    pack_in  = pack_reg;
    if (take_pix) pack_in[lane_cnt*PIX_W +: PIX_W] = pix_data;
    lane_sum  = lane_cnt + LW'(take_pix);
    word_full = (lane_sum == LANES);
    flush_req = (row_end || frame_end) && (lane_sum != '0);
  end

  always_comb begin
    lane_n    = lane_cnt;
    pack_n    = pack_reg;
    ptr_n     = addr_ptr;
    err_n     = addr_wrap_err;
    wr_n      = 1'b0;
    wr_data_n = dut_sram_write_data;
    wr_addr_n = dut_sram_write_address;
    done_n    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_n  = BASE_ADDR;
          lane_n = '0;
          pack_n = '0;
          err_n  = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (word_full || flush_req) begin
          wr_n      = 1'b1;
          wr_data_n = pack_in;
          wr_addr_n = addr_ptr;
          ptr_n     = addr_ptr + 12'd1;
          lane_n    = '0;
          pack_n    = '0;
          if (addr_ptr == 12'hFFF) err_n = 1'b1;
        end else begin
          lane_n = lane_sum;
          pack_n = pack_in;
        end
      end
      // Terminator goes to the next free address; the pointer is not advanced past it.
      S_FLUSH: begin
        wr_n      = 1'b1;
        wr_data_n = TERM_WORD;
        wr_addr_n = addr_ptr;
      end
      S_TERM:  done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      lane_cnt               <= '0;
      pack_reg               <= '0;
      addr_ptr               <= BASE_ADDR;
      addr_wrap_err          <= 1'b0;
      dut_sram_write_enable  <= 1'b0;
      dut_sram_write_data    <= '0;
      dut_sram_write_address <= BASE_ADDR;
      busy                   <= 1'b0;
      done                   <= 1'b0;
    end else begin
      lane_cnt               <= lane_n;
      pack_reg               <= pack_n;
      addr_ptr               <= ptr_n;
      addr_wrap_err          <= err_n;
      dut_sram_write_enable  <= wr_n;
      dut_sram_write_data    <= wr_data_n;
      dut_sram_write_address <= wr_addr_n;
      busy                   <= (state_n != S_IDLE);
      done                   <= done_n;
    end
  end

endmodule

// File: tb/tb_output_row_writer.sv
// Drives two writers (base 0x000 and base 0xFFF) with the same stimulus and checks
// every SRAM write and done pulse against a queue-based packing model.
module tb_output_row_writer;

  localparam logic [11:0] B0   = 12'h000;
  localparam logic [11:0] B1   = 12'hFFF;
  localparam logic [15:0] TERM = 16'h00FF;
  localparam int          PPW  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset_b = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start = 0, pix_valid = 0, row_end = 0, frame_end = 0;
  logic [7:0] pix_data = 0;

  logic [11:0] wa0, wa1;
  logic [15:0] wd0, wd1;
  logic        we0, we1, busy0, busy1, done0, done1, err0, err1;
  logic [2:0]  st0, st1;

  output_row_writer #(.BASE_ADDR(B0)) dut0 (
    .clk(clk), .reset_b(reset_b), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .row_end(row_end), .frame_end(frame_end), .dut_sram_write_address(wa0),
    .dut_sram_write_data(wd0), .dut_sram_write_enable(we0), .busy(busy0), .done(done0),
    .addr_wrap_err(err0), .state_dbg(st0));

  output_row_writer #(.BASE_ADDR(B1)) dut1 (
    .clk(clk), .reset_b(reset_b), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .row_end(row_end), .frame_end(frame_end), .dut_sram_write_address(wa1),
    .dut_sram_write_data(wd1), .dut_sram_write_enable(we1), .busy(busy1), .done(done1),
    .addr_wrap_err(err1), .state_dbg(st1));

  int n_vec = 0;
  int n_fail = 0;

  // scoreboard: entries are {cycle[31:0], addr[11:0], data[15:0]}
  logic [59:0] exp_q0[$];
  logic [59:0] exp_q1[$];
  int          done_q0[$];
  int          done_q1[$];

  // reference model
  int          m_mode = 0;      // 0 idle, 1 accepting, 2 finishing frame
  int          m_idle_from = 0;
  bit          m_off = 0;
  logic [7:0]  m_pix[$];
  logic [11:0] m_ptr[2];
  logic        m_err[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_emit(input int c, input logic [15:0] w, input bit is_term);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) exp_q0.push_back({32'(c), m_ptr[0], w});
      else        exp_q1.push_back({32'(c), m_ptr[1], w});
      if (!is_term) begin
        if (m_ptr[k] == 12'hFFF) m_err[k] = 1'b1;
        m_ptr[k] = m_ptr[k] + 12'd1;
      end
    end
  endtask

  task automatic model_step(input int d, input bit st, input bit pv, input logic [7:0] pd,
                            input bit re, input bit fe);
    logic [15:0] w;
    if (m_mode == 2 && d >= m_idle_from) m_mode = 0;
    if (m_mode == 1) begin
      if (pv) m_pix.push_back(pd);
      if (m_pix.size() == PPW || ((re || fe) && m_pix.size() > 0)) begin
        w = 16'h0;
        for (int i = 0; i < m_pix.size(); i++) w[i*8 +: 8] = m_pix[i];
        m_emit(d + 1, w, 1'b0);
        m_pix.delete();
      end
      if (fe) begin
        m_emit(d + 2, TERM, 1'b1);
        done_q0.push_back(d + 3);
        done_q1.push_back(d + 3);
        m_mode = 2;
        m_idle_from = d + 4;
      end
    end else if (m_mode == 0 && st) begin
      m_mode = 1;
      m_ptr[0] = B0;
      m_ptr[1] = B1;
      m_err[0] = 1'b0;
      m_err[1] = 1'b0;
      m_pix.delete();
    end
  endtask

  // driver: one call = one clock cycle of inputs
  task automatic drive(input bit st, input bit pv, input logic [7:0] pd, input bit re, input bit fe);
    @(posedge clk); #1;
    start = st; pix_valid = pv; pix_data = pd; row_end = re; frame_end = fe;
    if (!m_off) model_step(cyc, st, pv, pd, re, fe);
  endtask

  task automatic idle(input int n, input bit garbage);
    for (int i = 0; i < n; i++)
      if (garbage) drive(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
      else drive(0, 0, 8'h00, 0, 0);
  endtask

  task automatic end_frame(input string tag);
    idle(5, 1'b1);
    chk({tag, " busy0"}, 32'(busy0), 32'd0);
    chk({tag, " busy1"}, 32'(busy1), 32'd0);
    chk({tag, " wrap_err0"}, 32'(err0), 32'(m_err[0]));
    chk({tag, " wrap_err1"}, 32'(err1), 32'(m_err[1]));
  endtask

  // monitor
  task automatic mon_write(input int k, input logic we, input logic [11:0] a, input logic [15:0] d);
    logic [59:0] e;
    int sz;
    sz = (k == 0) ? exp_q0.size() : exp_q1.size();
    while (sz > 0) begin
      e = (k == 0) ? exp_q0[0] : exp_q1[0];
      if (int'(e[59:28]) >= cyc) break;
      n_vec++; n_fail++;
      $display("FAIL write%0d missing: got none expected %0h@%0h at cycle %0d", k, e[15:0], e[27:16], e[59:28]);
      if (k == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
      sz--;
    end
    if (!we) return;
    n_vec++;
    if (sz == 0) begin
      n_fail++;
      $display("FAIL write%0d unexpected: got %0h@%0h expected no write (cycle %0d)", k, d, a, cyc);
      return;
    end
    e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    if (e !== {32'(cyc), a, d}) begin
      n_fail++;
      $display("FAIL write%0d: got %0h@%0h cycle %0d expected %0h@%0h cycle %0d",
               k, d, a, cyc, e[15:0], e[27:16], e[59:28]);
    end
  endtask

  task automatic mon_done(input int k, input logic dn);
    int c;
    int sz;
    sz = (k == 0) ? done_q0.size() : done_q1.size();
    c  = (sz == 0) ? 0 : ((k == 0) ? done_q0[0] : done_q1[0]);
    if (sz > 0 && c < cyc) begin
      n_vec++; n_fail++;
      $display("FAIL done%0d missing: got 0 expected 1 at cycle %0d", k, c);
      if (k == 0) void'(done_q0.pop_front()); else void'(done_q1.pop_front());
      sz--;
      c = (sz == 0) ? 0 : ((k == 0) ? done_q0[0] : done_q1[0]);
    end
    if (!dn) return;
    n_vec++;
    if (sz == 0 || c != cyc) begin
      n_fail++;
      $display("FAIL done%0d: got pulse at cycle %0d expected cycle %0d", k, cyc, c);
      return;
    end
    if (k == 0) void'(done_q0.pop_front()); else void'(done_q1.pop_front());
  endtask

  always @(negedge clk) begin
    if (!reset_b) begin
      mon_write(0, we0, wa0, wd0);
      mon_write(1, we1, wa1, wd1);
      mon_done(0, done0);
      mon_done(1, done1);
    end
  end

  initial begin
    int len;
    // reset values
    repeat (2) @(negedge clk);
    chk("rst we0", 32'(we0), 32'd0);
    chk("rst we1", 32'(we1), 32'd0);
    chk("rst data0", 32'(wd0), 32'd0);
    chk("rst addr0", 32'(wa0), 32'(B0));
    chk("rst addr1", 32'(wa1), 32'(B1));
    chk("rst busy0", 32'(busy0), 32'd0);
    chk("rst done0", 32'(done0), 32'd0);
    chk("rst err1", 32'(err1), 32'd0);
    @(posedge clk); #1 reset_b = 1'b0;

    // reset mid-stream: a full word is on the write port when reset hits
    m_off = 1;
    drive(1, 0, 8'h00, 0, 0);
    drive(0, 1, 8'h11, 0, 0);
    drive(0, 1, 8'h22, 0, 0);
    @(posedge clk); #1;
    pix_valid = 0;
    chk("t1 we0 before reset", 32'(we0), 32'd1);
    chk("t1 we1 before reset", 32'(we1), 32'd1);
    reset_b = 1'b1;
    #1;
    chk("t1 we0 async drop", 32'(we0), 32'd0);
    chk("t1 we1 async drop", 32'(we1), 32'd0);
    @(posedge clk); #1 reset_b = 1'b0;
    m_off = 0;
    m_mode = 0;
    m_pix.delete();
    idle(3, 1'b1);
    chk("t1 busy0 after", 32'(busy0), 32'd0);
    chk("t1 addr0 after", 32'(wa0), 32'(B0));

    // ignored inputs while idle
    idle(6, 1'b1);

    // simple frame (dut1 also covers the address wrap)
    drive(1, 0, 8'h00, 0, 0);
    drive(0, 1, 8'h11, 0, 0);
    drive(0, 1, 8'h22, 0, 0);
    drive(0, 1, 8'h33, 0, 0);
    drive(0, 1, 8'h44, 0, 0);
    drive(0, 0, 8'h00, 0, 1);
    end_frame("t2");

    // partial-row flush, with a stray start during the frame
    drive(1, 0, 8'h00, 0, 0);
    drive(0, 1, 8'hA1, 0, 0);
    drive(1, 1, 8'hB2, 0, 0);
    drive(0, 1, 8'hC3, 1, 0);
    drive(0, 0, 8'h00, 0, 1);
    end_frame("t3");

    // empty row_end and frame_end
    drive(1, 0, 8'h00, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    drive(0, 0, 8'h00, 0, 0);
    drive(0, 0, 8'h00, 1, 1);
    end_frame("t4");

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      drive(1, 0, 8'h00, 0, 0);
      len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++)
        drive(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0), 8'($urandom),
              1'($urandom_range(0, 5) == 0), 0);
      drive(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1);
      end_frame("rand");
    end

    idle(5, 1'b0);
    chk("exp_q0 drained", 32'(exp_q0.size()), 32'd0);
    chk("exp_q1 drained", 32'(exp_q1.size()), 32'd0);
    chk("done_q0 drained", 32'(done_q0.size()), 32'd0);
    chk("done_q1 drained", 32'(done_q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
